wb_host_master: RTL and testbench

- Wishbone classic (B3, single-transfer) initiator inside the user project area, clocked from the management wishbone clock.
- Converts a simple valid/ready command stream (from LA/IO control logic) into one bus read or write at a time, and returns read data and status on a valid/ready response channel.
- Counterpart of the wrapper's slave-side `wbs_*` port: drives user-internal peripherals that expose the same responder interface.

---
 rtl/wb_master_pkg.sv | 19 +
 rtl/wb_timeout_ctr.sv | 28 ++
 rtl/wb_host_master.sv | 128 ++++++++++++
 tb/tb_wb_host_master.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_master_pkg.sv
// Shared types for the Wishbone host master: FSM states, response record, select width.
package wb_master_pkg;

    localparam int WBM_ADDR_W = 32;
    localparam int WBM_DATA_W = 32;
    localparam int SEL_W      = WBM_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wbm_state_t;

    typedef struct packed {
        logic [WBM_DATA_W-1:0] dat;
        logic                  err;
    } wbm_rsp_t;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Bus-cycle watchdog: counts while enabled and flags expiry on the TIMEOUT-th cycle.
// Only instantiated when WB_MASTER_TIMEOUT_EN is defined.
module wb_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int              CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = i_enable && (r_count == LAST);

endmodule

// File: rtl/wb_host_master.sv
// Wishbone classic single-transfer initiator driven by a valid/ready command stream.
// Optional bus timeout compiled in with WB_MASTER_TIMEOUT_EN.
module wb_host_master
    import wb_master_pkg::*;
#(
    parameter int ADDR_W  = WBM_ADDR_W,
    parameter int DATA_W  = WBM_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_adr,
    input  logic [DATA_W-1:0]     req_dat,
    input  logic [DATA_W/8-1:0]   req_sel,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_dat,
    output logic                  rsp_err,
    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_we_o,
    output logic [ADDR_W-1:0]     wbm_adr_o,
    output logic [DATA_W-1:0]     wbm_dat_o,
    output logic [DATA_W/8-1:0]   wbm_sel_o,
    input  logic [DATA_W-1:0]     wbm_dat_i,
    input  logic                  wbm_ack_i,
    input  logic                  wbm_err_i
);

    if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_bad_timeout
        $error("wb_host_master: TIMEOUT must be in 1..65535");
    end

    wbm_state_t r_state;
    wbm_state_t w_next;
    logic       w_expire;
    logic       w_abort;

`ifdef WB_MASTER_TIMEOUT_EN
    wb_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_clk    (wb_clk_i),
        .i_rst    (wb_rst_i),
        .i_clear  (r_state != BUS),
        .i_enable (r_state == BUS),
        .o_expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    // err wins over a simultaneous ack; a timeout behaves exactly like err
    assign w_abort   = wbm_err_i || w_expire;
    assign req_ready = (r_state == IDLE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_next = BUS;
            BUS:     if (w_abort || wbm_ack_i) w_next = RESP;
            RESP:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_dat   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= req_we;
                        wbm_adr_o <= req_adr;
                        wbm_dat_o <= req_dat;
                        wbm_sel_o <= req_sel;
                    end
                end
                BUS: begin
                    if (w_abort) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_dat   <= '0;
                    end else if (wbm_ack_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_dat   <= wbm_we_o ? '0 : wbm_dat_i;
                    end
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: begin
                    wbm_cyc_o <= 1'b0;
                    wbm_stb_o <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_host_master.sv
// Directed self-checking bench for wb_host_master (TIMEOUT=8; behaviour follows WB_MASTER_TIMEOUT_EN).
module tb_wb_host_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_adr, req_dat;
    logic [3:0]  req_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic        cyc, stb, we;
    logic [31:0] adr, dat_o, dat_i;
    logic [3:0]  sel;
    logic        ack, err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_host_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_adr   (req_adr),
        .req_dat   (req_dat),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .wbm_cyc_o (cyc),
        .wbm_stb_o (stb),
        .wbm_we_o  (we),
        .wbm_adr_o (adr),
        .wbm_dat_o (dat_o),
        .wbm_sel_o (sel),
        .wbm_dat_i (dat_i),
        .wbm_ack_i (ack),
        .wbm_err_i (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request and returns 1 time unit after the accepting edge.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int waited;
        req_valid = 1'b1;
        req_we    = w;
        req_adr   = a;
        req_dat   = d;
        req_sel   = s;
        waited    = 0;
        while (!req_ready && waited < 50) begin
            tick();
            waited++;
        end
        n_cmp++;
        if (!req_ready) begin
            n_fail++;
            $display("FAIL issue_accept: req_ready=%b required 1 within 50 cycles", req_ready);
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({cyc, stb, we, rsp_valid, rsp_err, req_ready} !== 6'b000001) begin
            n_fail++;
            $display("FAIL reset_ctrl: cyc/stb/we/rsp_valid/rsp_err/req_ready=%b required 000001",
                     {cyc, stb, we, rsp_valid, rsp_err, req_ready});
        end
        n_cmp++;
        if ({adr, dat_o, sel, rsp_dat} !== 100'd0) begin
            n_fail++;
            $display("FAIL reset_data: adr=%h dat_o=%h sel=%h rsp_dat=%h required all 0", adr, dat_o, sel, rsp_dat);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_ack();
        issue(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
        n_cmp++;
        if ({cyc, stb, we} !== 3'b111 || adr !== 32'h3000_0004 || dat_o !== 32'hDEAD_BEEF || sel !== 4'hF) begin
            n_fail++;
            $display("FAIL write_bus: cyc/stb/we=%b adr=%h dat=%h sel=%h required 111 30000004 deadbeef f",
                     {cyc, stb, we}, adr, dat_o, sel);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_cmp++;
        if ({cyc, stb, rsp_valid, rsp_err, req_ready} !== 5'b00100 || rsp_dat !== 32'h0) begin
            n_fail++;
            $display("FAIL write_rsp: cyc/stb/rsp_valid/rsp_err/req_ready=%b rsp_dat=%h required 00100 00000000",
                     {cyc, stb, rsp_valid, rsp_err, req_ready}, rsp_dat);
        end
        tick();
        n_cmp++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL write_done: rsp_valid/req_ready=%b required 01", {rsp_valid, req_ready});
        end
    endtask

    task automatic test_read_wait();
        int cnt;
        issue(1'b0, 32'h3000_0008, 32'h0, 4'hF);
        n_cmp++;
        if (we !== 1'b0 || adr !== 32'h3000_0008) begin
            n_fail++;
            $display("FAIL read_bus: we=%b adr=%h required 0 30000008", we, adr);
        end
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!cyc) break;
            cnt++;
            if (cnt == 4) begin
                ack   = 1'b1;
                dat_i = 32'h1234_5678;
            end
            tick();
            ack   = 1'b0;
            dat_i = 32'hFFFF_FFFF;
        end
        n_cmp++;
        if (cnt !== 4) begin
            n_fail++;
            $display("FAIL read_cyc_len: cyc high %0d cycles required 4", cnt);
        end
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL read_rsp: valid=%b err=%b dat=%h required 1 0 12345678", rsp_valid, rsp_err, rsp_dat);
        end
        tick();
    endtask

    task automatic test_rsp_hold();
        rsp_ready = 1'b0;
        issue(1'b0, 32'h3000_0010, 32'h0, 4'h3);
        ack   = 1'b1;
        dat_i = 32'hA5A5_0001;
        tick();
        ack   = 1'b0;
        dat_i = 32'h0;
        // a second request waits while the response is stalled
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_adr   = 32'h3000_0020;
        req_dat   = 32'h0BAD_F00D;
        req_sel   = 4'hC;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({rsp_valid, rsp_err, req_ready, cyc} !== 4'b1000 || rsp_dat !== 32'hA5A5_0001) begin
                n_fail++;
                $display("FAIL hold_c%0d: rsp_valid/err/req_ready/cyc=%b dat=%h required 1000 a5a50001",
                         i, {rsp_valid, rsp_err, req_ready, cyc}, rsp_dat);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        n_cmp++;
        if ({rsp_valid, req_ready, cyc} !== 3'b010) begin
            n_fail++;
            $display("FAIL hold_release: rsp_valid/req_ready/cyc=%b required 010", {rsp_valid, req_ready, cyc});
        end
        tick();
        req_valid = 1'b0;
        n_cmp++;
        if (cyc !== 1'b1 || we !== 1'b1 || adr !== 32'h3000_0020 || sel !== 4'hC) begin
            n_fail++;
            $display("FAIL hold_next: cyc=%b we=%b adr=%h sel=%h required 1 1 30000020 c", cyc, we, adr, sel);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
    endtask

    task automatic test_err(input logic with_ack, input string tag);
        issue(1'b0, 32'h3000_0030, 32'h0, 4'hF);
        err   = 1'b1;
        ack   = with_ack;
        dat_i = 32'hCAFE_CAFE;
        tick();
        err   = 1'b0;
        ack   = 1'b0;
        dat_i = 32'h0;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_dat !== 32'h0 || cyc !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: valid=%b err=%b dat=%h cyc=%b required 1 1 00000000 0",
                     tag, rsp_valid, rsp_err, rsp_dat, cyc);
        end
        tick();
    endtask

    task automatic test_timeout();
        int cnt;
        issue(1'b0, 32'h3000_0040, 32'h0, 4'hF);
`ifdef WB_MASTER_TIMEOUT_EN
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            if (!cyc) break;
            cnt++;
            tick();
        end
        n_cmp++;
        if (cnt !== 8) begin
            n_fail++;
            $display("FAIL timeout_len: cyc high %0d cycles required 8", cnt);
        end
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_dat !== 32'h0) begin
            n_fail++;
            $display("FAIL timeout_rsp: valid=%b err=%b dat=%h required 1 1 0", rsp_valid, rsp_err, rsp_dat);
        end
`else
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (cyc) cnt++;
            tick();
        end
        n_cmp++;
        if (cnt !== 100 || cyc !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL no_timeout: cyc high %0d of 100, cyc=%b rsp_valid=%b required 100 1 0",
                     cnt, cyc, rsp_valid);
        end
        err = 1'b1;
        tick();
        err = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin
            n_fail++;
            $display("FAIL no_timeout_err: valid=%b err=%b required 1 1", rsp_valid, rsp_err);
        end
`endif
        tick();
    endtask

    task automatic test_reset_mid_bus();
        issue(1'b0, 32'h3000_0050, 32'h0, 4'hF);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({cyc, stb, rsp_valid, req_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL midbus_reset: cyc/stb/rsp_valid/req_ready=%b required 0001",
                     {cyc, stb, rsp_valid, req_ready});
        end
        // stray ack while idle must not create a response
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        n_cmp++;
        if ({cyc, rsp_valid, req_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL stray_ack: cyc/rsp_valid/req_ready=%b required 001", {cyc, rsp_valid, req_ready});
        end
        issue(1'b0, 32'h3000_0060, 32'h0, 4'hF);
        ack   = 1'b1;
        dat_i = 32'h0F0F_1234;
        tick();
        ack   = 1'b0;
        dat_i = 32'h0;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== 32'h0F0F_1234) begin
            n_fail++;
            $display("FAIL post_reset_read: valid=%b err=%b dat=%h required 1 0 0f0f1234",
                     rsp_valid, rsp_err, rsp_dat);
        end
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_adr   = '0;
        req_dat   = '0;
        req_sel   = '0;
        rsp_ready = 1'b1;
        dat_i     = '0;
        ack       = 1'b0;
        err       = 1'b0;
        test_reset();
        test_write_ack();
        test_read_wait();
        test_rsp_hold();
        test_err(1'b0, "err_only");
        test_err(1'b1, "err_with_ack");
        test_timeout();
        test_reset_mid_bus();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
